// File: rtl/stack_queue_pkg.sv
// Shared types and sizing helpers for the LIFO/FIFO stack_queue buffer.
package stack_queue_pkg;

   typedef enum logic {
      MODE_LIFO = 1'b0,
      MODE_FIFO = 1'b1
   } sq_mode_e;

   localparam int SQ_WIDTH_DEF    = 16;
   localparam int SQ_DEPTH_P2_DEF = 8;

   // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an address.
   function automatic int cnt_width(input int depth_p2);
      return depth_p2 + 1;
   endfunction

endpackage

// File: rtl/stack_queue_if.sv
// Producer/consumer port bundle of stack_queue; slave = buffer side, master = user side.
interface stack_queue_if
   import stack_queue_pkg::*;
#(
   parameter int WIDTH    = SQ_WIDTH_DEF,
   parameter int DEPTH_P2 = SQ_DEPTH_P2_DEF
) ();

   // push/pop are plain requests taken on every rising edge they are high; there is
   // no ready signal, acceptance is reported afterwards via count/full/empty and the
   // sticky overflow/underflow flags, and read data is qualified by dout_valid.
   logic                                mode;
   logic                                push;
   logic [WIDTH-1:0]                    din;
   logic                                pop;
   logic                                clr_err;
   logic [WIDTH-1:0]                    dout;
   logic                                dout_valid;
   logic                                empty;
   logic                                full;
   logic                                almost_empty;
   logic                                almost_full;
   logic [cnt_width(DEPTH_P2)-1:0]      count;
   logic                                overflow;
   logic                                underflow;

   modport slave (
      input  mode, push, din, pop, clr_err,
      output dout, dout_valid, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );

   modport master (
      output mode, push, din, pop, clr_err,
      input  dout, dout_valid, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );

endinterface

// File: rtl/stack_queue_regfile.sv
// Storage array for stack_queue: one write port, one registered read port that
// returns the pre-write contents when both ports hit the same address.
module sq_regfile #(
   parameter int WIDTH = 16,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [2**AW];
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   // Contents deliberately survive reset; only the occupancy bookkeeping is cleared.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/stack_queue.sv
// Runtime-selectable LIFO/FIFO buffer with occupancy count, threshold flags,
// registered read data with valid strobe, and sticky overflow/underflow errors.
module stack_queue
   import stack_queue_pkg::*;
#(
   parameter int WIDTH     = SQ_WIDTH_DEF,
   parameter int DEPTH_P2  = SQ_DEPTH_P2_DEF,
   parameter int AFULL_TH  = (2**DEPTH_P2) - 4,
   parameter int AEMPTY_TH = 4
) (
   input logic          clk,
   input logic          reset,
   stack_queue_if.slave sq
);

   localparam int            CW       = cnt_width(DEPTH_P2);
   localparam int            AW       = DEPTH_P2;
   localparam logic [CW-1:0] DEPTH_C  = CW'(2**DEPTH_P2);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   sq_mode_e      mode_q, mode_d;
   logic          dv_q, dv_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          aempty_q, aempty_d;
   logic          afull_q, afull_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   sq_mode_e         mode_eff;
   logic             pop_ok;
   logic             push_ok;
   logic [AW-1:0]    top_addr;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] rdata;

   always_comb begin
      // Mode is only allowed to change while the buffer holds nothing.
      mode_eff = (count_q == '0) ? sq_mode_e'(sq.mode) : mode_q;
      mode_d   = mode_eff;

      pop_ok   = sq.pop & ~empty_q;
      push_ok  = sq.push & (~full_q | pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      top_addr = count_q[AW-1:0] - AW'(1);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (mode_eff == MODE_LIFO) begin
         // Simultaneous push+pop replaces the top entry in place.
         raddr = top_addr;
         waddr = pop_ok ? top_addr : count_q[AW-1:0];
      end else begin
         raddr = rd_ptr_q;
         waddr = wr_ptr_q;
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (count_d == '0) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end

      dv_d     = pop_ok;
      empty_d  = (count_d == '0);
      full_d   = (count_d == DEPTH_C);
      aempty_d = (count_d <= AEMPTY_C);
      afull_d  = (count_d >= AFULL_C);

      // A new error event takes priority over a same-cycle clear.
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (sq.clr_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (sq.push & ~push_ok) ovf_d = 1'b1;
      if (sq.pop  & ~pop_ok)  unf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mode_q   <= MODE_LIFO;
         dv_q     <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mode_q   <= mode_d;
         dv_q     <= dv_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   sq_regfile #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (push_ok),
      .waddr (waddr),
      .wdata (sq.din),
      .re    (pop_ok),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign sq.dout         = rdata;
   assign sq.dout_valid   = dv_q;
   assign sq.empty        = empty_q;
   assign sq.full         = full_q;
   assign sq.almost_empty = aempty_q;
   assign sq.almost_full  = afull_q;
   assign sq.count        = count_q;
   assign sq.overflow     = ovf_q;
   assign sq.underflow    = unf_q;

endmodule

// File: tb/tb_stack_queue.sv
// Directed + random bench driving a 256-deep and a 4-deep stack_queue in lockstep
// against a queue-based reference model and a read-data scoreboard.
module tb_stack_queue;

   logic clk;
   logic reset;

   stack_queue_if #(.WIDTH(16), .DEPTH_P2(8)) if_big ();
   stack_queue_if #(.WIDTH(16), .DEPTH_P2(2)) if_small ();

   stack_queue u_big (
      .clk   (clk),
      .reset (reset),
      .sq    (if_big)
   );

   stack_queue #(
      .WIDTH     (16),
      .DEPTH_P2  (2),
      .AFULL_TH  (3),
      .AEMPTY_TH (1)
   ) u_small (
      .clk   (clk),
      .reset (reset),
      .sq    (if_small)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish (limit 500000 ns)");
      $fatal(1, "timeout");
   end

   // ---------------- reference model + scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   int          depth_t  [2] = '{256, 4};
   int          afull_t  [2] = '{252, 3};
   int          aempty_t [2] = '{4, 1};
   logic [15:0] mdl   [2][$];
   logic [15:0] exp_q [2][$];
   logic        m_mode [2];
   logic        m_ovf  [2];
   logic        m_unf  [2];
   logic        m_dv   [2];
   logic [15:0] m_dout [2];
   logic        cur_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_update(input int i, input logic p, input logic [15:0] d,
                               input logic q, input logic md, input logic ce,
                               input logic rst);
      int          n;
      logic        m;
      logic        pop_ok;
      logic        push_ok;
      logic [15:0] v;
      if (rst) begin
         mdl[i].delete();
         exp_q[i].delete();
         m_mode[i] = 1'b0;
         m_ovf[i]  = 1'b0;
         m_unf[i]  = 1'b0;
         m_dv[i]   = 1'b0;
         m_dout[i] = '0;
      end else begin
         n         = mdl[i].size();
         m         = (n == 0) ? md : m_mode[i];
         m_mode[i] = m;
         pop_ok    = q && (n > 0);
         push_ok   = p && ((n < depth_t[i]) || pop_ok);
         if (pop_ok) begin
            v = m ? mdl[i].pop_front() : mdl[i].pop_back();
            exp_q[i].push_back(v);
            m_dout[i] = v;
         end
         if (push_ok) mdl[i].push_back(d);
         m_dv[i] = pop_ok;
         if (p && !push_ok) m_ovf[i] = 1'b1;
         else if (ce)       m_ovf[i] = 1'b0;
         if (q && !pop_ok)  m_unf[i] = 1'b1;
         else if (ce)       m_unf[i] = 1'b0;
      end
   endtask

   task automatic check_dut(input int i, input string nm, input logic [31:0] cnt,
                            input logic emp, input logic ful, input logic ae,
                            input logic af, input logic ovf, input logic unf,
                            input logic dv, input logic [15:0] dout);
      int          n;
      logic [15:0] e;
      n = mdl[i].size();
      chk({nm, "_count"},        cnt, n);
      chk({nm, "_empty"},        emp, (n == 0));
      chk({nm, "_full"},         ful, (n == depth_t[i]));
      chk({nm, "_almost_empty"}, ae,  (n <= aempty_t[i]));
      chk({nm, "_almost_full"},  af,  (n >= afull_t[i]));
      chk({nm, "_overflow"},     ovf, m_ovf[i]);
      chk({nm, "_underflow"},    unf, m_unf[i]);
      chk({nm, "_dout_valid"},   dv,  m_dv[i]);
      if (dv === 1'b1 && exp_q[i].size() > 0) begin
         e = exp_q[i].pop_front();
         chk({nm, "_dout"}, dout, e);
      end else begin
         chk({nm, "_dout_hold"}, dout, m_dout[i]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic p, input logic [15:0] d, input logic q,
                       input logic ce, input logic rst);
      reset            = rst;
      if_big.mode      = cur_mode;
      if_big.push      = p;
      if_big.din       = d;
      if_big.pop       = q;
      if_big.clr_err   = ce;
      if_small.mode    = cur_mode;
      if_small.push    = p;
      if_small.din     = d;
      if_small.pop     = q;
      if_small.clr_err = ce;
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_update(i, p, d, q, cur_mode, ce, rst);
      #1;
      check_dut(0, "big", 32'(if_big.count), if_big.empty, if_big.full,
                if_big.almost_empty, if_big.almost_full, if_big.overflow,
                if_big.underflow, if_big.dout_valid, if_big.dout);
      check_dut(1, "small", 32'(if_small.count), if_small.empty, if_small.full,
                if_small.almost_empty, if_small.almost_full, if_small.overflow,
                if_small.underflow, if_small.dout_valid, if_small.dout);
   endtask

   task automatic do_push(input logic [15:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
   task automatic do_pop();                      step(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
   task automatic do_pp(input logic [15:0] d);   step(1'b1, d, 1'b1, 1'b0, 1'b0); endtask
   task automatic do_idle();                     step(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
   task automatic do_clr();                      step(1'b0, '0, 1'b0, 1'b1, 1'b0); endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic        rp, rq, rc;
      logic [15:0] rd;
      cur_mode = 1'b0;
      reset    = 1'b1;
      if_big.mode = 1'b0;   if_big.push = 1'b0;   if_big.din = '0;
      if_big.pop = 1'b0;    if_big.clr_err = 1'b0;
      if_small.mode = 1'b0; if_small.push = 1'b0; if_small.din = '0;
      if_small.pop = 1'b0;  if_small.clr_err = 1'b0;

      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_count", 32'(if_big.count), 32'd0);
      chk("rst_empty", if_big.empty, 1'b1);
      do_idle();

      // LIFO ordering
      cur_mode = 1'b0;
      do_push(16'd1); do_push(16'd2); do_push(16'd3);
      do_pop(); chk("lifo_pop1", if_big.dout, 16'd3);
      do_pop(); chk("lifo_pop2", if_big.dout, 16'd2);
      do_pop(); chk("lifo_pop3", if_big.dout, 16'd1);
      chk("lifo_empty", if_big.empty, 1'b1);
      do_idle();
      chk("lifo_dv_pulse", if_big.dout_valid, 1'b0);

      // FIFO ordering, mode change while non-empty ignored
      cur_mode = 1'b1;
      do_push(16'd1); do_push(16'd2); do_push(16'd3);
      cur_mode = 1'b0;
      do_pop(); chk("fifo_pop1", if_big.dout, 16'd1);
      do_pop(); chk("fifo_pop2", if_big.dout, 16'd2);
      do_pop(); chk("fifo_pop3", if_big.dout, 16'd3);
      do_idle();

      // Small instance: full, overflow, push+pop when full, pointer wrap
      cur_mode = 1'b1;
      for (int k = 0; k < 5; k++) do_push(16'h10 + 16'(k));
      chk("small_full", if_small.full, 1'b1);
      chk("small_ovf", if_small.overflow, 1'b1);
      do_pp(16'h20);
      chk("small_pp_full_dout", if_small.dout, 16'h10);
      do_pop(); do_pop();
      do_push(16'h30); do_push(16'h31);
      for (int k = 0; k < 4; k++) do_pop();
      chk("small_wrap_last", if_small.dout, 16'h31);
      do_pop();
      do_clr();
      chk("small_ovf_clr", if_small.overflow, 1'b0);
      do_idle();

      // LIFO push+pop replaces top
      cur_mode = 1'b0;
      do_push(16'd7); do_push(16'd9);
      do_pp(16'd4);
      chk("lifo_pp_dout", if_big.dout, 16'd9);
      chk("lifo_pp_count", 32'(if_big.count), 32'd2);
      do_pop(); chk("lifo_pp_next", if_big.dout, 16'd4);
      do_pop(); chk("lifo_pp_last", if_big.dout, 16'd7);

      // push+pop while empty: push taken, pop rejected, no bypass
      do_pp(16'hA);
      chk("empty_pp_count", 32'(if_big.count), 32'd1);
      chk("empty_pp_unf", if_big.underflow, 1'b1);
      chk("empty_pp_dv", if_big.dout_valid, 1'b0);
      do_pop(); chk("empty_pp_pop", if_big.dout, 16'hA);
      do_clr();

      // Threshold flags across the full range of the large instance
      cur_mode = 1'b1;
      for (int k = 0; k < 253; k++) do_push(16'($urandom_range(0, 65535)));
      for (int k = 0; k < 250; k++) do_pop();
      chk("thr_aempty_at3", if_big.almost_empty, 1'b1);

      // Reset in the middle of a fill
      for (int k = 0; k < 10; k++) do_push(16'($urandom_range(0, 65535)));
      step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
      chk("midrst_count", 32'(if_big.count), 32'd0);
      chk("midrst_dout", if_big.dout, 16'd0);
      do_idle();

      // Random mix of requests, modes and clears
      for (int k = 0; k < 300; k++) begin
         rp       = 1'($urandom_range(0, 1));
         rq       = 1'($urandom_range(0, 1));
         rc       = ($urandom_range(0, 15) == 0);
         rd       = 16'($urandom_range(0, 65535));
         cur_mode = 1'($urandom_range(0, 1));
         step(rp, rd, rq, rc, 1'b0);
      end

      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      do_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
